// File: rtl/segment_builder.sv
// -----------------------------------------------------------------------------
// segment_builder
//
// Upstream feeder for the collision detector. Absolute toolhead points arrive
// on a valid/ready handshake and are buffered in a small FIFO. Consecutive
// extruding points are turned into line segments. Each segment is presented
// on a one-cycle out_val strobe. Emissions are paced by GAP idle cycles,
// zero-length moves are dropped, and emission saturates at MAX_SEGS.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   start               synchronous job clear (one cycle, highest priority)
//   pt_val / pt_rdy     input point handshake (pt_rdy = !fifo_full && !start)
//   px, py, pz          8-bit unsigned point coordinates
//   extrude             1 = draw from previous point, 0 = travel move
//   out_val             one-cycle segment strobe
//   x1..z2              registered segment start / end coordinates
//   seg_cnt             segments emitted this job
//   full                sticky: MAX_SEGS reached, later segments discarded
// -----------------------------------------------------------------------------
module segment_builder #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2,
  parameter int MAX_SEGS   = 51
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pt_val,
  output logic       pt_rdy,
  input  logic [7:0] px,
  input  logic [7:0] py,
  input  logic [7:0] pz,
  input  logic       extrude,
  output logic       out_val,
  output logic [7:0] x1,
  output logic [7:0] y1,
  output logic [7:0] z1,
  output logic [7:0] x2,
  output logic [7:0] y2,
  output logic [7:0] z2,
  output logic [7:0] seg_cnt,
  output logic       full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Wide enough to hold GAP; stays at least one bit when GAP is 0.
  localparam int GW = $clog2(GAP + 2);

  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);
  localparam logic [7:0]    SEG_LIMIT = 8'(MAX_SEGS);

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } coord_t;

  typedef struct packed {
    coord_t c;
    logic   e;
  } point_t;

  typedef enum logic [1:0] {
    S_NOANCHOR = 2'd0,
    S_ANCHORED = 2'd1,
    S_PACE     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Point FIFO: pointers carry one extra wrap bit so full/empty are told apart.
  // ---------------------------------------------------------------------------
  point_t        mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  point_t        head;

  state_t        state_q, state_d;
  coord_t        anchor_q, anchor_d;
  coord_t        seg_a_q, seg_a_d;
  coord_t        seg_b_q, seg_b_d;
  logic          out_val_q, out_val_d;
  logic [7:0]    seg_cnt_q, seg_cnt_d;
  logic          full_q, full_d;
  logic [GW-1:0] gap_q, gap_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pt_rdy = !fifo_full && !start;
  assign push   = pt_val && pt_rdy;
  assign pop    = !fifo_empty && (gap_q == '0) && !start;
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: the buffer storage has no reset; only the pointers define validity,
  // so clearing the array would cost reset routing and buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{c: '{x: px, y: py, z: pz}, e: extrude};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: start clears the job; otherwise classify the popped point.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    anchor_d  = anchor_q;
    seg_a_d   = seg_a_q;
    seg_b_d   = seg_b_q;
    out_val_d = 1'b0;
    seg_cnt_d = seg_cnt_q;
    full_d    = full_q;
    gap_d     = (gap_q != '0) ? gap_q - GAP_ONE : gap_q;
    wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    if (start) begin
      state_d   = S_NOANCHOR;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      seg_cnt_d = '0;
      full_d    = 1'b0;
      gap_d     = '0;
    end else begin
      unique case (state_q)
        S_NOANCHOR: begin
          if (pop) begin
            anchor_d = head.c;
            state_d  = S_ANCHORED;
          end
        end
        S_ANCHORED: begin
          if (pop) begin
            if (!head.e) begin
              anchor_d = head.c;                 // travel move re-anchors
            end else if (head.c != anchor_q) begin  // zero-length is dropped
              anchor_d = head.c;
              if (seg_cnt_q == SEG_LIMIT) begin
                full_d = 1'b1;
              end else begin
                seg_a_d   = anchor_q;
                seg_b_d   = head.c;
                out_val_d = 1'b1;
                seg_cnt_d = seg_cnt_q + 8'd1;
                gap_d     = GAP_LOAD;
                if (GAP > 0) state_d = S_PACE;
              end
            end
          end
        end
        S_PACE: begin
          if (gap_q == GAP_ONE) state_d = S_ANCHORED;
        end
        default: state_d = S_NOANCHOR;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_NOANCHOR;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      anchor_q  <= '0;
      seg_a_q   <= '0;
      seg_b_q   <= '0;
      out_val_q <= 1'b0;
      seg_cnt_q <= '0;
      full_q    <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      anchor_q  <= anchor_d;
      seg_a_q   <= seg_a_d;
      seg_b_q   <= seg_b_d;
      out_val_q <= out_val_d;
      seg_cnt_q <= seg_cnt_d;
      full_q    <= full_d;
      gap_q     <= gap_d;
    end
  end

  assign out_val = out_val_q;
  assign x1      = seg_a_q.x;
  assign y1      = seg_a_q.y;
  assign z1      = seg_a_q.z;
  assign x2      = seg_b_q.x;
  assign y2      = seg_b_q.y;
  assign z2      = seg_b_q.z;
  assign seg_cnt = seg_cnt_q;
  assign full    = full_q;

endmodule
